id_ex_register: RTL and testbench

Decode-to-Execute pipeline register of the RV32i 5-stage pipelined core. It captures all decode-stage control, select, register-file and PC signals on each rising clock edge and presents them to the execute stage one cycle later. It supports asynchronous reset and a synchronous flush, which inserts a bubble (NOP) on branch mispredict or load-use hazard.

---
 rtl/id_ex_register.sv | 143 ++++++++++++++
 tb/tb_id_ex_register.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// Decode-to-Execute pipeline register: one-cycle capture, async reset to zero, flush inserts a NOP bubble.
// Defining IDEX_STALL_EN adds a Stall_E input that holds the current contents (flush and reset still win).
module id_ex_register #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] BUBBLE_PC = XLEN'(32'h2A2A_2A2A)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            Flush_E,
`ifdef IDEX_STALL_EN
   input  logic            Stall_E,
`endif
   input  logic            REG_W_En_D,
   input  logic            MEM_W_En_D,
   input  logic            Jump_En_D,
   input  logic            Branch_En_D,
   input  logic [2:0]      MEM_Control_D,
   input  logic [3:0]      ALU_Control_D,
   input  logic            Branch_Src_Sel_D,
   input  logic            ALU_SrcA_Sel_D,
   input  logic            ALU_SrcB_Sel_D,
   input  logic [1:0]      Result_Src_Sel_D,
   input  logic [4:0]      RD_D,
   input  logic [4:0]      RS1_D,
   input  logic [4:0]      RS2_D,
   input  logic [XLEN-1:0] REG_R_Data1_D,
   input  logic [XLEN-1:0] REG_R_Data2_D,
   input  logic [XLEN-1:0] Imm_Ext_D,
   input  logic [XLEN-1:0] PC_D,
   input  logic [XLEN-1:0] PC_Plus_4_D,
   input  logic            Predict_Taken_D,
   output logic            REG_W_En_E,
   output logic            MEM_W_En_E,
   output logic            Jump_En_E,
   output logic            Branch_En_E,
   output logic [2:0]      MEM_Control_E,
   output logic [3:0]      ALU_Control_E,
   output logic            Branch_Src_Sel_E,
   output logic            ALU_SrcA_Sel_E,
   output logic            ALU_SrcB_Sel_E,
   output logic [1:0]      Result_Src_Sel_E,
   output logic [4:0]      RD_E,
   output logic [4:0]      RS1_E,
   output logic [4:0]      RS2_E,
   output logic [XLEN-1:0] REG_R_Data1_E,
   output logic [XLEN-1:0] REG_R_Data2_E,
   output logic [XLEN-1:0] Imm_Ext_E,
   output logic [XLEN-1:0] PC_E,
   output logic [XLEN-1:0] PC_Plus_4_E,
   output logic            Predict_Taken_E
);

   typedef struct packed {
      logic            reg_w_en;
      logic            mem_w_en;
      logic            jump_en;
      logic            branch_en;
      logic [2:0]      mem_control;
      logic [3:0]      alu_control;
      logic            branch_src_sel;
      logic            alu_srca_sel;
      logic            alu_srcb_sel;
      logic [1:0]      result_src_sel;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] rdata1;
      logic [XLEN-1:0] rdata2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus_4;
      logic            predict_taken;
   } id_ex_t;

   id_ex_t stage_in;
   id_ex_t stage_d;
   id_ex_t stage_q;

   always_comb begin
      stage_in.reg_w_en       = REG_W_En_D;
      stage_in.mem_w_en       = MEM_W_En_D;
      stage_in.jump_en        = Jump_En_D;
      stage_in.branch_en      = Branch_En_D;
      stage_in.mem_control    = MEM_Control_D;
      stage_in.alu_control    = ALU_Control_D;
      stage_in.branch_src_sel = Branch_Src_Sel_D;
      stage_in.alu_srca_sel   = ALU_SrcA_Sel_D;
      stage_in.alu_srcb_sel   = ALU_SrcB_Sel_D;
      stage_in.result_src_sel = Result_Src_Sel_D;
      stage_in.rd             = RD_D;
      stage_in.rs1            = RS1_D;
      stage_in.rs2            = RS2_D;
      stage_in.rdata1         = REG_R_Data1_D;
      stage_in.rdata2         = REG_R_Data2_D;
      stage_in.imm            = Imm_Ext_D;
      stage_in.pc             = PC_D;
      stage_in.pc_plus_4      = PC_Plus_4_D;
      stage_in.predict_taken  = Predict_Taken_D;
   end

   // The bubble is built from constants only, so X on the _D inputs cannot leak through a flush.
   always_comb begin
      // NOTE: stage_d is assigned on every path before any branch, so no latch is inferred.
      stage_d = stage_in;
      if (Flush_E) begin
         stage_d           = '0;
         stage_d.pc        = BUBBLE_PC;
         stage_d.pc_plus_4 = BUBBLE_PC;
      end
`ifdef IDEX_STALL_EN
      else if (Stall_E) begin
         stage_d = stage_q;
      end
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
      if (RST) stage_q <= '0;
      else     stage_q <= stage_d;
   end

   assign REG_W_En_E       = stage_q.reg_w_en;
   assign MEM_W_En_E       = stage_q.mem_w_en;
   assign Jump_En_E        = stage_q.jump_en;
   assign Branch_En_E      = stage_q.branch_en;
   assign MEM_Control_E    = stage_q.mem_control;
   assign ALU_Control_E    = stage_q.alu_control;
   assign Branch_Src_Sel_E = stage_q.branch_src_sel;
   assign ALU_SrcA_Sel_E   = stage_q.alu_srca_sel;
   assign ALU_SrcB_Sel_E   = stage_q.alu_srcb_sel;
   assign Result_Src_Sel_E = stage_q.result_src_sel;
   assign RD_E             = stage_q.rd;
   assign RS1_E            = stage_q.rs1;
   assign RS2_E            = stage_q.rs2;
   assign REG_R_Data1_E    = stage_q.rdata1;
   assign REG_R_Data2_E    = stage_q.rdata2;
   assign Imm_Ext_E        = stage_q.imm;
   assign PC_E             = stage_q.pc;
   assign PC_Plus_4_E      = stage_q.pc_plus_4;
   assign Predict_Taken_E  = stage_q.predict_taken;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: vector table plus reset/flush/stall sequences, scoreboard-checked.
// Define IDEX_STALL_EN for both RTL and bench to exercise the stall sequences.
module tb_id_ex_register;

   typedef struct packed {
      logic        reg_w_en;
      logic        mem_w_en;
      logic        jump_en;
      logic        branch_en;
      logic [2:0]  mem_control;
      logic [3:0]  alu_control;
      logic        branch_src_sel;
      logic        alu_srca_sel;
      logic        alu_srcb_sel;
      logic [1:0]  result_src_sel;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc_plus_4;
      logic        predict_taken;
   } bundle_t;

   typedef struct {
      bit      flush;
      bundle_t in;
      bundle_t exp;
   } vec_t;

   localparam int NVEC = 12;

   logic    CLK = 1'b0;
   logic    RST;
   logic    flush_e;
`ifdef IDEX_STALL_EN
   logic    stall_e;
`endif
   bundle_t in_b;
   bundle_t out_b;

   logic        reg_w_en_e, mem_w_en_e, jump_en_e, branch_en_e;
   logic [2:0]  mem_control_e;
   logic [3:0]  alu_control_e;
   logic        branch_src_sel_e, alu_srca_sel_e, alu_srcb_sel_e;
   logic [1:0]  result_src_sel_e;
   logic [4:0]  rd_e, rs1_e, rs2_e;
   logic [31:0] rdata1_e, rdata2_e, imm_e, pc_e, pc_plus_4_e;
   logic        predict_taken_e;

   int n_checks = 0;
   int n_pass   = 0;
   bundle_t sb[$];
   vec_t    tbl[NVEC];

   always #5 CLK = ~CLK;

   id_ex_register dut (
      .CLK              (CLK),
      .RST              (RST),
      .Flush_E          (flush_e),
`ifdef IDEX_STALL_EN
      .Stall_E          (stall_e),
`endif
      .REG_W_En_D       (in_b.reg_w_en),
      .MEM_W_En_D       (in_b.mem_w_en),
      .Jump_En_D        (in_b.jump_en),
      .Branch_En_D      (in_b.branch_en),
      .MEM_Control_D    (in_b.mem_control),
      .ALU_Control_D    (in_b.alu_control),
      .Branch_Src_Sel_D (in_b.branch_src_sel),
      .ALU_SrcA_Sel_D   (in_b.alu_srca_sel),
      .ALU_SrcB_Sel_D   (in_b.alu_srcb_sel),
      .Result_Src_Sel_D (in_b.result_src_sel),
      .RD_D             (in_b.rd),
      .RS1_D            (in_b.rs1),
      .RS2_D            (in_b.rs2),
      .REG_R_Data1_D    (in_b.rdata1),
      .REG_R_Data2_D    (in_b.rdata2),
      .Imm_Ext_D        (in_b.imm),
      .PC_D             (in_b.pc),
      .PC_Plus_4_D      (in_b.pc_plus_4),
      .Predict_Taken_D  (in_b.predict_taken),
      .REG_W_En_E       (reg_w_en_e),
      .MEM_W_En_E       (mem_w_en_e),
      .Jump_En_E        (jump_en_e),
      .Branch_En_E      (branch_en_e),
      .MEM_Control_E    (mem_control_e),
      .ALU_Control_E    (alu_control_e),
      .Branch_Src_Sel_E (branch_src_sel_e),
      .ALU_SrcA_Sel_E   (alu_srca_sel_e),
      .ALU_SrcB_Sel_E   (alu_srcb_sel_e),
      .Result_Src_Sel_E (result_src_sel_e),
      .RD_E             (rd_e),
      .RS1_E            (rs1_e),
      .RS2_E            (rs2_e),
      .REG_R_Data1_E    (rdata1_e),
      .REG_R_Data2_E    (rdata2_e),
      .Imm_Ext_E        (imm_e),
      .PC_E             (pc_e),
      .PC_Plus_4_E      (pc_plus_4_e),
      .Predict_Taken_E  (predict_taken_e)
   );

   assign out_b = {reg_w_en_e, mem_w_en_e, jump_en_e, branch_en_e, mem_control_e, alu_control_e,
                   branch_src_sel_e, alu_srca_sel_e, alu_srcb_sel_e, result_src_sel_e,
                   rd_e, rs1_e, rs2_e, rdata1_e, rdata2_e, imm_e, pc_e, pc_plus_4_e,
                   predict_taken_e};

   function automatic bundle_t rand_bundle();
      bundle_t b;
      b.reg_w_en       = 1'($urandom);
      b.mem_w_en       = 1'($urandom);
      b.jump_en        = 1'($urandom);
      b.branch_en      = 1'($urandom);
      b.mem_control    = 3'($urandom);
      b.alu_control    = 4'($urandom);
      b.branch_src_sel = 1'($urandom);
      b.alu_srca_sel   = 1'($urandom);
      b.alu_srcb_sel   = 1'($urandom);
      b.result_src_sel = 2'($urandom);
      b.rd             = 5'($urandom);
      b.rs1            = 5'($urandom);
      b.rs2            = 5'($urandom);
      b.rdata1         = $urandom;
      b.rdata2         = $urandom;
      b.imm            = $urandom;
      b.pc             = $urandom;
      b.pc_plus_4      = $urandom;
      b.predict_taken  = 1'($urandom);
      return b;
   endfunction

   function automatic bundle_t bubble();
      bundle_t b = '0;
      b.pc        = 32'h2A2A_2A2A;
      b.pc_plus_4 = 32'h2A2A_2A2A;
      return b;
   endfunction

   task automatic check(input string name, input bundle_t act, input bundle_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic edge_check(input string name);
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty, got %h expected an entry", name, out_b);
      end else begin
         check(name, out_b, sb.pop_front());
      end
   endtask

   initial begin
      bundle_t b, b200, b300;

      // Table: 5 pass-through, flush, resume, 3 back-to-back flushes (X inputs in one), resume x2.
      for (int i = 0; i < NVEC; i++) begin
         tbl[i].in    = rand_bundle();
         tbl[i].flush = (i == 5) || (i >= 7 && i <= 9);
      end
      tbl[0].in.rdata1 = 32'hDEAD_BEEF;
      tbl[0].in.rd     = 5'd17;
      tbl[0].in.alu_control = 4'hA;
      tbl[5].in.reg_w_en = 1'b1;
      tbl[5].in.mem_w_en = 1'b1;
      tbl[5].in.jump_en  = 1'b1;
      tbl[5].in.branch_en = 1'b1;
      tbl[5].in.pc        = 32'h100;
      tbl[5].in.pc_plus_4 = 32'h104;
      tbl[8].in.rdata1   = 'x;
      tbl[8].in.imm      = 'x;
      tbl[8].in.pc       = 'x;
      tbl[8].in.reg_w_en = 1'bx;
      for (int i = 0; i < NVEC; i++)
         tbl[i].exp = tbl[i].flush ? bubble() : tbl[i].in;

      RST     = 1'b1;
      flush_e = 1'b0;
`ifdef IDEX_STALL_EN
      stall_e = 1'b0;
`endif
      in_b    = rand_bundle();
      #3;
      check("reset_initial", out_b, '0);
      @(posedge CLK);
      #1;
      check("reset_hold", out_b, '0);
      RST = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         in_b    = tbl[i].in;
         flush_e = tbl[i].flush;
         sb.push_back(tbl[i].exp);
         edge_check($sformatf("vec%0d", i));
      end
      flush_e = 1'b0;

      // Asynchronous reset between edges, then reset held against a flush request.
      b = rand_bundle();
      b.reg_w_en = 1'b1;
      b.pc       = 32'h0000_0444;
      in_b = b;
      sb.push_back(b);
      edge_check("pre_reset_capture");
      #3;
      RST = 1'b1;
      #1;
      check("async_reset_midcycle", out_b, '0);
      flush_e = 1'b1;
      in_b.reg_w_en  = 1'b1;
      in_b.mem_w_en  = 1'b1;
      in_b.jump_en   = 1'b1;
      in_b.branch_en = 1'b1;
      in_b.pc        = 32'h100;
      in_b.pc_plus_4 = 32'h104;
      @(posedge CLK);
      #1;
      check("reset_over_flush", out_b, '0);
      #3;
      RST     = 1'b0;
      flush_e = 1'b0;
      b = rand_bundle();
      in_b = b;
      sb.push_back(b);
      edge_check("first_edge_after_reset");

`ifdef IDEX_STALL_EN
      b200 = rand_bundle();
      b200.pc = 32'h200;
      b300 = rand_bundle();
      b300.pc = 32'h300;
      in_b = b200;
      sb.push_back(b200);
      edge_check("stall_load_200");
      in_b    = b300;
      stall_e = 1'b1;
      sb.push_back(b200);
      edge_check("stall_hold_1");
      sb.push_back(b200);
      edge_check("stall_hold_2");
      flush_e = 1'b1;
      sb.push_back(bubble());
      edge_check("flush_over_stall");
      flush_e = 1'b0;
      stall_e = 1'b0;
      sb.push_back(b300);
      edge_check("stall_release");
`else
      b200 = '0;
      b300 = '0;
      if (b200 !== b300) $display("unreachable");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
